// File: rtl/gray_ptr_sync_decoder.sv
// Resynchronises a foreign-domain gray pointer, decodes it to binary and presents each new
// value with its delta over a valid/ready handshake. Define GRAY_SYNC_ERR_CHK_EN for err_o.
module gray_ptr_sync_decoder #(
  parameter int unsigned VEC_W       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [VEC_W-1:0] gray_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [VEC_W-1:0] bin_o,
  output logic [VEC_W-1:0] delta_o,
  output logic             err_o
);

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  logic [VEC_W-1:0] sync_q [SYNC_STAGES];
  logic [VEC_W-1:0] sync_gray;
  logic [VEC_W-1:0] dec_d, dec_q;
  logic [VEC_W-1:0] acc_d, acc_q;
  logic [VEC_W-1:0] bin_d, bin_q;
  logic [VEC_W-1:0] delta_d, delta_q;
  logic             valid_d, valid_q;
  state_e           state_d, state_q;

  // Plain flop chain: nothing may sit between stages.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_gray = sync_q[SYNC_STAGES-1];

  always_comb begin
    dec_d = '0;
    for (int unsigned i = 0; i < VEC_W; i++) begin
      dec_d[i] = ^(sync_gray >> i);
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    bin_d   = bin_q;
    delta_d = delta_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (dec_q != acc_q) begin
          bin_d   = dec_q;
          delta_d = dec_q - acc_q;
          valid_d = 1'b1;
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (ready_i) begin
          acc_d = bin_q;
          // Back-to-back: anything absorbed while stalled is reported right away.
          if (dec_q != bin_q) begin
            bin_d   = dec_q;
            delta_d = dec_q - bin_q;
          end else begin
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dec_q   <= '0;
      acc_q   <= '0;
      bin_q   <= '0;
      delta_q <= '0;
      valid_q <= 1'b0;
      state_q <= StIdle;
    end else begin
      dec_q   <= dec_d;
      acc_q   <= acc_d;
      bin_q   <= bin_d;
      delta_q <= delta_d;
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

  assign valid_o = valid_q;
  assign bin_o   = bin_q;
  assign delta_o = delta_q;

`ifdef GRAY_SYNC_ERR_CHK_EN
  logic [VEC_W-1:0] prev_q;
  logic             err_d, err_q;
  int unsigned      flips;

  // A legal gray step flips at most one bit between consecutive synced samples.
  always_comb begin
    flips = 0;
    for (int unsigned i = 0; i < VEC_W; i++) begin
      flips = flips + {31'd0, sync_gray[i] ^ prev_q[i]};
    end
    err_d = (flips > 1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= sync_gray;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync_decoder.sv
// Randomised and directed bench for gray_ptr_sync_decoder against a transaction-level model.
module tb_gray_ptr_sync_decoder;

  localparam int S = 2;
`ifdef GRAY_SYNC_ERR_CHK_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] gray_i = '0;
  logic       ready_i = 1'b0;
  logic       valid_o, err_o;
  logic [3:0] bin_o, delta_o;

  int n_checks = 0;
  int n_fail = 0;

  logic       m_valid, m_err;
  logic [3:0] m_bin, m_delta, m_acc;
  logic [3:0] hist [0:S];

  gray_ptr_sync_decoder #(.VEC_W(4), .SYNC_STAGES(S)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .gray_i  (gray_i),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .bin_o   (bin_o),
    .delta_o (delta_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Inverse by search over the code table rather than by bit-wise decode.
  function automatic logic [3:0] to_bin(input logic [3:0] g);
    for (int v = 0; v < 16; v++) begin
      if (to_gray(4'(v)) == g) return 4'(v);
    end
    return 4'd0;
  endfunction

  task automatic step(input logic rst_n, input logic [3:0] g, input logic rdy);
    logic [3:0] dec, nacc;
    reset_n = rst_n;
    gray_i  = g;
    ready_i = rdy;
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_bin = '0; m_delta = '0; m_acc = '0; m_err = 1'b0;
      for (int j = 0; j <= S; j++) hist[j] = '0;
    end else begin
      dec   = to_bin(hist[S]);
      m_err = ErrEn && ($countones(hist[S-1] ^ hist[S]) > 1);
      nacc  = (m_valid && rdy) ? m_bin : m_acc;
      if (!m_valid || rdy) begin
        if (dec != nacc) begin
          m_delta = dec - nacc;
          m_bin   = dec;
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      m_acc = nacc;
      for (int j = S; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = g;
    end
    #1;
    check_eq("valid", {31'd0, valid_o}, {31'd0, m_valid});
    check_eq("bin", {28'd0, bin_o}, {28'd0, m_bin});
    check_eq("delta", {28'd0, delta_o}, {28'd0, m_delta});
    check_eq("err", {31'd0, err_o}, {31'd0, m_err});
  endtask

  task automatic wait_valid(input string tag, input logic [3:0] g, input logic rdy);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, g, rdy);
      if (valid_o) break;
    end
    check_eq(tag, {31'd0, valid_o}, 32'd1);
  endtask

  initial begin
    logic [3:0] cnt;
    logic       rst, rdy;
    int         r;

    // Reset and idle hold
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    check_eq("t1_rst_valid", {31'd0, valid_o}, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0000, 1'b0);
    check_eq("t1_hold_valid", {31'd0, valid_o}, 32'd0);
    check_eq("t1_hold_bin", {28'd0, bin_o}, 32'd0);

    // First value, latency of four edges
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0001, 1'b1);
    check_eq("t2_early_valid", {31'd0, valid_o}, 32'd0);
    step(1'b1, 4'b0001, 1'b1);
    check_eq("t2_valid", {31'd0, valid_o}, 32'd1);
    check_eq("t2_bin", {28'd0, bin_o}, 32'd1);
    check_eq("t2_delta", {28'd0, delta_o}, 32'd1);
    step(1'b1, 4'b0001, 1'b1);
    check_eq("t2_drop", {31'd0, valid_o}, 32'd0);

    // Stalled presentation absorbs later changes
    step(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0001, 1'b0);
    step(1'b1, 4'b0011, 1'b0);
    step(1'b1, 4'b0011, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0010, 1'b0);
    check_eq("t3_held_bin", {28'd0, bin_o}, 32'd1);
    step(1'b1, 4'b0010, 1'b1);
    check_eq("t3_valid", {31'd0, valid_o}, 32'd1);
    check_eq("t3_bin", {28'd0, bin_o}, 32'd3);
    check_eq("t3_delta", {28'd0, delta_o}, 32'd2);

    // Count up to 15 then wrap to 0
    for (int c = 4; c < 16; c++) begin
      step(1'b1, to_gray(4'(c)), 1'b1);
      step(1'b1, to_gray(4'(c)), 1'b1);
    end
    for (int i = 0; i < 6; i++) step(1'b1, 4'b1000, 1'b1);
    wait_valid("t4_valid", 4'b0000, 1'b0);
    check_eq("t4_bin", {28'd0, bin_o}, 32'd0);
    check_eq("t4_delta", {28'd0, delta_o}, 32'd1);

    // Illegal two-bit jump
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0000, 1'b1);
    step(1'b1, 4'b0011, 1'b0);
    step(1'b1, 4'b0011, 1'b0);
    step(1'b1, 4'b0011, 1'b0);
    check_eq("t5_err", {31'd0, err_o}, {31'd0, ErrEn});
    step(1'b1, 4'b0011, 1'b0);
    check_eq("t5_err_end", {31'd0, err_o}, 32'd0);
    check_eq("t5_valid", {31'd0, valid_o}, 32'd1);
    check_eq("t5_bin", {28'd0, bin_o}, 32'd2);
    check_eq("t5_delta", {28'd0, delta_o}, 32'd2);

    // Reset mid-handshake discards the pending value
    step(1'b0, 4'b0110, 1'b0);
    check_eq("t6_rst_valid", {31'd0, valid_o}, 32'd0);
    wait_valid("t6_valid", 4'b0110, 1'b0);
    check_eq("t6_bin", {28'd0, bin_o}, 32'd4);
    check_eq("t6_delta", {28'd0, delta_o}, 32'd4);

    // Random walk with occasional jumps, stalls and resets
    cnt = 4'd4;
    for (int i = 0; i < 2000; i++) begin
      r   = int'($urandom_range(0, 99));
      rst = (r >= 2);
      if (r < 8) cnt = 4'($urandom);
      else if (r < 50) cnt = cnt + 4'd1;
      rdy = ($urandom_range(0, 3) != 0);
      step(rst, to_gray(cnt), rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
